// File: rtl/aha_ahb_pkg.sv
// Shared AHB-Lite encodings and state types for the AhaCM3 interconnect blocks.
package aha_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'b00,
    ERR_1    = 2'b01,
    ERR_2    = 2'b10
  } err_state_e;

  typedef enum logic [1:0] {
    DSEL_NONE    = 2'b00,
    DSEL_REGION  = 2'b01,
    DSEL_DEFAULT = 2'b10
  } dsel_kind_e;

endpackage

// File: rtl/aha_ahb_default_slave.sv
// AHB default slave: two-cycle ERROR response plus saturating error count,
// last-error address and a one-cycle interrupt pulse.
module aha_ahb_default_slave
  import aha_ahb_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [31:0]          haddr,
  output logic                 hreadyout,
  output logic [1:0]           hresp,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          err_addr,
  output logic                 err_irq,
  output err_state_e           state_o
);

  err_state_e           state_q, state_d;
  logic [31:0]          pend_addr_q, pend_addr_d;
  logic [31:0]          err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    err_irq     = 1'b0;
    case (state_q)
      ERR_IDLE: begin
        if (capture) begin
          state_d     = ERR_1;
          pend_addr_d = haddr;
        end
      end
      ERR_1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ERR_2;
      end
      ERR_2: begin
        hresp      = HRESP_ERROR;
        err_irq    = 1'b1;
        err_addr_d = pend_addr_q;
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
        // A new faulting address phase completing in ERR2 chains straight into ERR1.
        if (capture) begin
          state_d     = ERR_1;
          pend_addr_d = haddr;
        end else begin
          state_d = ERR_IDLE;
        end
      end
      default: state_d = ERR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ERR_IDLE;
      pend_addr_q <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
  assign state_o   = state_q;

endmodule

// File: rtl/aha_ahb_multi_region.sv
// AHB-Lite slave port split into NUM_REGIONS contiguous equal windows, with a
// default slave answering every selected transfer that falls outside them.
module aha_ahb_multi_region
  import aha_ahb_pkg::*;
#(
  parameter int          NUM_REGIONS      = 2,
  parameter int          REGION_ADDR_BITS = 17,
  parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
  parameter int          ERR_CNT_W        = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic                     HREADY,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HSIZE,
  input  logic                     HWRITE,
  input  logic [31:0]              HADDR,
  input  logic [31:0]              HWDATA,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [31:0]              HRDATA,
  output logic [NUM_REGIONS-1:0]   S_HSEL,
  input  logic [NUM_REGIONS-1:0]   S_HREADYOUT,
  input  logic [2*NUM_REGIONS-1:0] S_HRESP,
  input  logic [32*NUM_REGIONS-1:0] S_HRDATA,
  output logic [ERR_CNT_W-1:0]     ERR_COUNT,
  output logic [31:0]              ERR_ADDR,
  output logic                     ERR_IRQ
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [31:0]      addr_off, addr_idx;
  logic             in_range, xfer_valid, err_capture;
  dsel_kind_e       dsel_kind_q, dsel_kind_d;
  logic [IDX_W-1:0] dsel_idx_q, dsel_idx_d;
  logic             def_hreadyout;
  logic [1:0]       def_hresp;
  err_state_e       err_state;
  logic             unused_inputs;

  always_comb begin
    addr_off = HADDR - BASE_ADDR;
    addr_idx = addr_off >> REGION_ADDR_BITS;
    in_range = (HADDR >= BASE_ADDR) && (addr_idx < 32'(NUM_REGIONS));
    for (int i = 0; i < NUM_REGIONS; i++) begin
      S_HSEL[i] = HSEL && in_range && (addr_idx == 32'(i));
    end
  end

  // Handshake: an address phase is taken only on a clock edge where HREADY=1;
  // while HREADY=0 the previous data phase is still open and dsel holds.
  assign xfer_valid  = HSEL && HTRANS[1];
  assign err_capture = HREADY && xfer_valid && !in_range;

  always_comb begin
    dsel_kind_d = dsel_kind_q;
    dsel_idx_d  = dsel_idx_q;
    if (HREADY) begin
      if (xfer_valid && in_range) begin
        dsel_kind_d = DSEL_REGION;
        dsel_idx_d  = addr_idx[IDX_W-1:0];
      end else if (xfer_valid) begin
        dsel_kind_d = DSEL_DEFAULT;
      end else begin
        dsel_kind_d = DSEL_NONE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_kind_q <= DSEL_NONE;
      dsel_idx_q  <= '0;
    end else begin
      dsel_kind_q <= dsel_kind_d;
      dsel_idx_q  <= dsel_idx_d;
    end
  end

  aha_ahb_default_slave #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_default_slave (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .capture   (err_capture),
    .haddr     (HADDR),
    .hreadyout (def_hreadyout),
    .hresp     (def_hresp),
    .err_count (ERR_COUNT),
    .err_addr  (ERR_ADDR),
    .err_irq   (ERR_IRQ),
    .state_o   (err_state)
  );

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (dsel_kind_q)
      DSEL_REGION: begin
        HREADYOUT = S_HREADYOUT[dsel_idx_q];
        HRESP     = S_HRESP[2*dsel_idx_q +: 2];
        HRDATA    = S_HRDATA[32*dsel_idx_q +: 32];
      end
      DSEL_DEFAULT: begin
        HREADYOUT = def_hreadyout;
        HRESP     = def_hresp;
      end
      default: ;
    endcase
  end

  // Write-side and size signals are routed to the windows outside this block.
  assign unused_inputs = ^{HSIZE, HWRITE, HWDATA, HTRANS[0], err_state};

endmodule

// File: tb/tb_aha_ahb_multi_region.sv
// Self-checking bench for aha_ahb_multi_region: directed AHB scenarios plus
// randomized traffic against a transfer-level reference model.
module tb_aha_ahb_multi_region;
  import aha_ahb_pkg::*;

  localparam int          N     = 2;
  localparam longint      WIN   = 64'd1 << 17;
  localparam logic [31:0] BASE3 = 32'h0002_0000;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          waits;
  } xfer_t;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic            hsel, hwrite, hready;
  logic [1:0]      htrans;
  logic [2:0]      hsize;
  logic [31:0]     haddr, hwdata;
  logic [N-1:0]    s_hreadyout;
  logic [2*N-1:0]  s_hresp;
  logic [32*N-1:0] s_hrdata;

  logic            hreadyout, err_irq;
  logic [1:0]      hresp;
  logic [31:0]     hrdata, err_addr;
  logic [N-1:0]    s_hsel;
  logic [15:0]     err_count;

  logic            hreadyout_2, err_irq_2;
  logic [1:0]      hresp_2;
  logic [31:0]     hrdata_2, err_addr_2;
  logic [N-1:0]    s_hsel_2;
  logic [1:0]      err_count_2;

  logic            hreadyout_3, err_irq_3;
  logic [1:0]      hresp_3;
  logic [31:0]     hrdata_3, err_addr_3;
  logic [N-1:0]    s_hsel_3;
  logic [15:0]     err_count_3;

  // The bus returns the block's own ready as HREADY, as in a single-slave system.
  assign hready = hreadyout;

  aha_ahb_multi_region #(.NUM_REGIONS(N), .REGION_ADDR_BITS(17), .BASE_ADDR(32'h0), .ERR_CNT_W(16)) dut (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .HRDATA(hrdata), .S_HSEL(s_hsel), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
    .S_HRDATA(s_hrdata), .ERR_COUNT(err_count), .ERR_ADDR(err_addr), .ERR_IRQ(err_irq));

  aha_ahb_multi_region #(.NUM_REGIONS(N), .REGION_ADDR_BITS(17), .BASE_ADDR(32'h0), .ERR_CNT_W(2)) dut_sat (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata), .HREADYOUT(hreadyout_2), .HRESP(hresp_2),
    .HRDATA(hrdata_2), .S_HSEL(s_hsel_2), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
    .S_HRDATA(s_hrdata), .ERR_COUNT(err_count_2), .ERR_ADDR(err_addr_2), .ERR_IRQ(err_irq_2));

  aha_ahb_multi_region #(.NUM_REGIONS(N), .REGION_ADDR_BITS(17), .BASE_ADDR(BASE3), .ERR_CNT_W(16)) dut_base (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata), .HREADYOUT(hreadyout_3), .HRESP(hresp_3),
    .HRDATA(hrdata_3), .S_HSEL(s_hsel_3), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
    .S_HRDATA(s_hrdata), .ERR_COUNT(err_count_3), .ERR_ADDR(err_addr_3), .ERR_IRQ(err_irq_3));

  int          errors = 0;
  int          checks = 0;
  int          irq_pulses = 0;
  int          irq2_pulses = 0;
  logic [15:0] cnt_exp = '0;
  logic [1:0]  cnt2_exp = '0;
  logic [31:0] eaddr_exp = '0;
  logic [31:0] exp_q[$];
  xfer_t       seq_q[$];

  // Reference decode: window number, or -2 when the address is outside all windows.
  function automatic int region_of(input logic [31:0] addr, input logic [31:0] base);
    longint a = longint'({32'b0, addr});
    longint b = longint'({32'b0, base});
    longint r;
    if (a < b) return -2;
    r = (a - b) / WIN;
    if (r >= N) return -2;
    return int'(r);
  endfunction

  function automatic int target_of(input xfer_t x);
    if (!(x.sel && (x.trans == HTRANS_NONSEQ || x.trans == HTRANS_SEQ))) return -1;
    return region_of(x.addr, 32'h0);
  endfunction

  function automatic logic [N-1:0] hsel_exp(input logic sel, input logic [31:0] addr, input logic [31:0] base);
    logic [N-1:0] v = '0;
    int r = region_of(addr, base);
    if (sel && r >= 0) v[r] = 1'b1;
    return v;
  endfunction

  function automatic void push_xfer(input logic sel, input logic [1:0] trans, input logic wr,
                                    input logic [31:0] addr, input logic [31:0] rdata, input int waits);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.wr = wr; x.size = 3'd2;
    x.addr = addr; x.rdata = rdata; x.waits = waits;
    seq_q.push_back(x);
  endfunction

  task automatic drive_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; hsize = 3'd2; hwrite = 1'b0; haddr = '0; hwdata = '0;
    s_hreadyout = '1; s_hresp = '0; s_hrdata = '0;
  endtask

  // Runs seq_q as a pipelined AHB stream and checks every cycle. Enter and leave at posedge+1.
  task automatic run_seq();
    int    ai = 0;
    bit    dv = 0;
    xfer_t cur;
    int    tgt = -1;
    int    ph = 0;
    int    end_ph;
    int    cyc = 0;
    logic  rdy;
    logic  exp_rdy, exp_irq;
    logic [1:0]  exp_resp;
    logic [31:0] exp_d;
    logic [N-1:0] eh;
    while ((ai < seq_q.size() || dv) && cyc < 3000) begin
      cyc++;
      if (ai < seq_q.size()) begin
        hsel = seq_q[ai].sel; htrans = seq_q[ai].trans; hwrite = seq_q[ai].wr;
        hsize = seq_q[ai].size; haddr = seq_q[ai].addr; hwdata = $urandom;
      end else begin
        hsel = 1'b0; htrans = HTRANS_IDLE; haddr = $urandom;
      end
      for (int i = 0; i < N; i++) begin
        s_hreadyout[i] = 1'($urandom_range(0, 1));
        s_hresp[2*i +: 2] = {1'b0, 1'($urandom_range(0, 1))};
        s_hrdata[32*i +: 32] = $urandom;
      end
      if (dv && tgt >= 0) begin
        s_hreadyout[tgt] = (ph >= cur.waits);
        s_hresp[2*tgt +: 2] = HRESP_OKAY;
        s_hrdata[32*tgt +: 32] = cur.rdata;
      end
      @(negedge hclk);
      end_ph   = (tgt >= 0) ? cur.waits : ((tgt == -2) ? 1 : 0);
      exp_rdy  = !dv || (ph == end_ph);
      exp_resp = (dv && tgt == -2) ? HRESP_ERROR : HRESP_OKAY;
      exp_irq  = dv && (tgt == -2) && (ph == 1);
      checks++;
      if (hreadyout !== exp_rdy) begin
        errors++; $display("FAIL hreadyout: got %b expected %b addr=%h ph=%0d", hreadyout, exp_rdy, cur.addr, ph);
      end
      checks++;
      if (hresp !== exp_resp) begin
        errors++; $display("FAIL hresp: got %b expected %b addr=%h ph=%0d", hresp, exp_resp, cur.addr, ph);
      end
      checks++;
      if (err_irq !== exp_irq || err_irq_2 !== exp_irq) begin
        errors++; $display("FAIL err_irq: got %b/%b expected %b", err_irq, err_irq_2, exp_irq);
      end
      eh = hsel_exp(hsel, haddr, 32'h0);
      checks++;
      if (s_hsel !== eh) begin
        errors++; $display("FAIL s_hsel: got %b expected %b haddr=%h", s_hsel, eh, haddr);
      end
      eh = hsel_exp(hsel, haddr, BASE3);
      checks++;
      if (s_hsel_3 !== eh) begin
        errors++; $display("FAIL s_hsel_base: got %b expected %b haddr=%h", s_hsel_3, eh, haddr);
      end
      checks++;
      if (err_count !== cnt_exp || err_count_2 !== cnt2_exp) begin
        errors++; $display("FAIL err_count: got %0d/%0d expected %0d/%0d", err_count, err_count_2, cnt_exp, cnt2_exp);
      end
      checks++;
      if (err_addr !== eaddr_exp) begin
        errors++; $display("FAIL err_addr: got %h expected %h", err_addr, eaddr_exp);
      end
      if (err_irq) irq_pulses++;
      if (err_irq_2) irq2_pulses++;
      if (dv && exp_rdy) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (hrdata !== exp_d) begin
          errors++; $display("FAIL hrdata: got %h expected %h addr=%h", hrdata, exp_d, cur.addr);
        end
      end else if (!dv) begin
        checks++;
        if (hrdata !== 32'h0) begin
          errors++; $display("FAIL hrdata_idle: got %h expected 0", hrdata);
        end
      end
      rdy = hreadyout;
      @(posedge hclk);
      #1;
      if (dv && tgt == -2 && ph == 1) begin
        if (cnt_exp != 16'hFFFF) cnt_exp++;
        if (cnt2_exp != 2'b11) cnt2_exp++;
        eaddr_exp = cur.addr;
      end
      if (dv && rdy) dv = 0;
      else if (dv) ph++;
      if (rdy && ai < seq_q.size()) begin
        cur = seq_q[ai];
        ai++;
        tgt = target_of(cur);
        ph = 0;
        dv = 1;
        exp_q.push_back((tgt >= 0) ? cur.rdata : 32'h0);
      end
    end
    if (cyc >= 3000) begin
      errors++; checks++;
      $display("FAIL run_seq_timeout: got %0d cycles expected completion of %0d transfers", cyc, seq_q.size());
    end
    hsel = 1'b0; htrans = HTRANS_IDLE;
    seq_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    drive_idle();
    hsel = 1'b1; haddr = 32'h0002_0004;
    #12;
    checks++;
    if (hreadyout !== 1'b1 || hresp !== HRESP_OKAY || hrdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got rdy=%b resp=%b data=%h expected 1/00/0", hreadyout, hresp, hrdata);
    end
    checks++;
    if (err_count !== 16'h0 || err_addr !== 32'h0 || err_irq !== 1'b0) begin
      errors++; $display("FAIL reset_err: got cnt=%0d addr=%h irq=%b expected 0/0/0", err_count, err_addr, err_irq);
    end
    checks++;
    if (s_hsel !== 2'b10) begin
      errors++; $display("FAIL reset_s_hsel: got %b expected 10", s_hsel);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    hsel = 1'b0;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_single_read();
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0000_0100, 32'hCAFE_0001, 0);
    run_seq();
  endtask

  task automatic test_back_to_back();
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0002_0004, 32'hB1B1_0001, 2);
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0000_0008, 32'hA0A0_0002, 0);
    run_seq();
  endtask

  task automatic test_default_error();
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0004_0000, 32'h1111_1111, 0);
    run_seq();
    checks++;
    if (err_count !== 16'd1 || err_addr !== 32'h0004_0000) begin
      errors++; $display("FAIL default_error: got cnt=%0d addr=%h expected 1/00040000", err_count, err_addr);
    end
  endtask

  task automatic test_err_pipeline();
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0010_0000, 32'h0, 0);
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b1, 32'h0010_0004, 32'h0, 0);
    run_seq();
    checks++;
    if (err_count !== 16'd3 || err_addr !== 32'h0010_0004) begin
      errors++; $display("FAIL err_pipeline: got cnt=%0d addr=%h expected 3/00100004", err_count, err_addr);
    end
  endtask

  task automatic test_saturation();
    int p0 = irq2_pulses;
    for (int k = 0; k < 5; k++) push_xfer(1'b1, HTRANS_SEQ, 1'b0, 32'h8000_0000 + 32'(4 * k), 32'h0, 0);
    run_seq();
    checks++;
    if (err_count_2 !== 2'd3 || (irq2_pulses - p0) != 5) begin
      errors++; $display("FAIL saturation: got cnt=%0d pulses=%0d expected 3/5", err_count_2, irq2_pulses - p0);
    end
    checks++;
    if (err_count !== 16'd8) begin
      errors++; $display("FAIL count_wide: got %0d expected 8", err_count);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      int          b;
      logic [31:0] a;
      b = $urandom_range(0, 5);
      case (b)
        0, 1:    a = 32'($urandom_range(0, 32'h3FFFF)) & 32'hFFFF_FFFC;
        2:       a = 32'h0003_FFFF;
        3:       a = 32'h0004_0000;
        4:       a = $urandom;
        default: a = 32'hFFFF_FFFC;
      endcase
      push_xfer(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                a, $urandom, $urandom_range(0, 3));
    end
    run_seq();
  endtask

  task automatic test_reset_mid_error();
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h0004_0000;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    checks++;
    if (hreadyout !== 1'b0 || hresp !== HRESP_ERROR) begin
      errors++; $display("FAIL err1_state: got rdy=%b resp=%b expected 0/01", hreadyout, hresp);
    end
    #2 hresetn = 1'b0;
    #1;
    checks++;
    if (hreadyout !== 1'b1 || hresp !== HRESP_OKAY || hrdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid_bus: got rdy=%b resp=%b data=%h expected 1/00/0", hreadyout, hresp, hrdata);
    end
    checks++;
    if (err_count !== 16'h0 || err_count_2 !== 2'h0 || err_addr !== 32'h0 || err_irq !== 1'b0) begin
      errors++; $display("FAIL reset_mid_err: got cnt=%0d addr=%h irq=%b expected 0/0/0", err_count, err_addr, err_irq);
    end
    cnt_exp = '0; cnt2_exp = '0; eaddr_exp = '0;
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    push_xfer(1'b1, HTRANS_NONSEQ, 1'b0, 32'h0000_0000, 32'h1234_5678, 0);
    run_seq();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_default_error();
    test_err_pipeline();
    test_saturation();
    test_random();
    test_reset_mid_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
